// File: rtl/rom_loader_if.sv
// rom_loader_if: bundles the hps_io download stream and the ROM write port
// so the loader and its host connect through one port.
interface rom_loader_if #(
  parameter int ADDRWIDTH = 14
);
  logic                 ioctl_download;
  logic [7:0]           ioctl_index;
  logic [24:0]          ioctl_addr;
  logic [7:0]           ioctl_dout;
  logic                 ioctl_wr;
  logic                 ioctl_wait;
  logic [ADDRWIDTH-1:0] mem_addr;
  logic [7:0]           mem_data;
  logic                 mem_wren;

  // Host side: drives the download stream, observes wait and the write port
  modport master (
    output ioctl_download, ioctl_index, ioctl_addr, ioctl_dout, ioctl_wr,
    input  ioctl_wait, mem_addr, mem_data, mem_wren
  );

  // Loader side: consumes the download stream, drives the write port
  modport slave (
    input  ioctl_download, ioctl_index, ioctl_addr, ioctl_dout, ioctl_wr,
    output ioctl_wait, mem_addr, mem_data, mem_wren
  );
endinterface

// File: rtl/rom_loader.sv
// rom_loader: writes one ioctl download image into the write port of a
// dual-port ROM, then pads the unwritten tail with a fill byte so a short
// image never leaves stale data from an earlier load.
module rom_loader #(
  parameter int       ADDRWIDTH = 14,
  parameter bit [7:0] INDEX     = 8'd1,
  parameter bit [7:0] FILL      = 8'hFF
) (
  input  logic               clock,
  input  logic               reset_n,
  rom_loader_if.slave        bus,
  output logic               busy,
  output logic               done,
  output logic [ADDRWIDTH:0] size
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_FILL,
    S_DONE
  } state_t;

  // Address math carries one extra bit so the fill counter and size can
  // represent the full region depth without wrapping to zero.
  localparam logic [ADDRWIDTH:0] DEPTH      = {1'b1, {ADDRWIDTH{1'b0}}};
  localparam logic [ADDRWIDTH:0] LAST       = {1'b0, {ADDRWIDTH{1'b1}}};
  localparam logic [ADDRWIDTH:0] ONE        = {{ADDRWIDTH{1'b0}}, 1'b1};
  localparam logic [24:0]        ADDR_LIMIT = 25'(1) << ADDRWIDTH;

  state_t             state, state_n;
  logic [ADDRWIDTH:0] addr_q, addr_n;
  logic [7:0]         data_q, data_n;
  logic               wren_q, wren_n;
  logic               wait_q, wait_n;
  logic               busy_q, busy_n;
  logic               done_q, done_n;
  logic [ADDRWIDTH:0] size_q, size_n;

  logic               sel;
  logic               in_range;
  logic [ADDRWIDTH:0] addr_plus;
  logic               finish_load;

  assign sel       = bus.ioctl_download && (bus.ioctl_index == INDEX);
  assign in_range  = bus.ioctl_addr < ADDR_LIMIT;
  assign addr_plus = {1'b0, bus.ioctl_addr[ADDRWIDTH-1:0]} + ONE;

  assign bus.mem_addr   = addr_q[ADDRWIDTH-1:0];
  assign bus.mem_data   = data_q;
  assign bus.mem_wren   = wren_q;
  assign bus.ioctl_wait = wait_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign size           = size_q;

  // Next-state and next-output logic; every output is computed here and
  // registered below so nothing from ioctl_* reaches an output combinationally.
  always_comb begin
    state_n     = state;
    addr_n      = addr_q;
    data_n      = data_q;
    wren_n      = 1'b0;
    wait_n      = 1'b0;
    size_n      = size_q;
    done_n      = done_q;
    finish_load = 1'b0;

    case (state)
      S_IDLE, S_DONE: begin
        if (sel) begin
          state_n = S_LOAD;
          size_n  = '0;
          done_n  = 1'b0;
        end
      end
      S_LOAD: begin
        if (sel && bus.ioctl_wr) begin
          if (in_range) begin
            addr_n  = {1'b0, bus.ioctl_addr[ADDRWIDTH-1:0]};
            data_n  = bus.ioctl_dout;
            wren_n  = 1'b1;
            wait_n  = 1'b1;
            state_n = S_WRITE;
            if (addr_plus > size_q) begin
              size_n = addr_plus;
            end
          end else begin
            size_n = DEPTH;
          end
        end else if (!sel) begin
          finish_load = 1'b1;
        end
      end
      S_WRITE: begin
        if (sel) begin
          state_n = S_LOAD;
        end else begin
          finish_load = 1'b1;
        end
      end
      S_FILL: begin
        if (sel) begin
          state_n = S_LOAD;
          size_n  = '0;
        end else if (addr_q == LAST) begin
          state_n = S_DONE;
          done_n  = 1'b1;
        end else begin
          addr_n = addr_q + ONE;
          data_n = FILL;
          wren_n = 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    if (finish_load) begin
      if (size_q < DEPTH) begin
        state_n = S_FILL;
        addr_n  = size_q;
        data_n  = FILL;
        wren_n  = 1'b1;
      end else begin
        state_n = S_DONE;
        done_n  = 1'b1;
      end
    end

    busy_n = (state_n == S_LOAD) || (state_n == S_WRITE) || (state_n == S_FILL);
  end

  // State and output registers; reset drops straight back to idle without
  // touching memory contents.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      addr_q <= '0;
      data_q <= '0;
      wren_q <= 1'b0;
      wait_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      size_q <= '0;
    end else begin
      state  <= state_n;
      addr_q <= addr_n;
      data_q <= data_n;
      wren_q <= wren_n;
      wait_q <= wait_n;
      busy_q <= busy_n;
      done_q <= done_n;
      size_q <= size_n;
    end
  end

endmodule

// File: doc/rom_loader.md
# rom_loader

Writer side of the on-chip ROM/RAM blocks: accepts the HPS `ioctl` download byte stream for one file index and writes it into the write port of a dual-port ROM image. It runs one byte write per accepted `ioctl_wr`. At the end of a download it pads the unwritten tail of the region with a fill byte, so a short image never leaves stale contents from a previous load. It sits between `hps_io` and the `data_b`/`address_b`/`wren_b` side of the ROM instance; the CPU-side port is untouched.

## Interface
Parameters:
- `ADDRWIDTH`, 14: address width of the target memory; region depth is 2^ADDRWIDTH bytes.
- `INDEX`, 8'd1: `ioctl_index` value this loader responds to.
- `FILL`, 8'hFF: byte written into the unloaded tail.

Ports:
- `clock`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ioctl_download`  in  1  download in progress.
- `ioctl_index`  in  8  file index of the current download.
- `ioctl_addr`  in  25  byte address of `ioctl_dout`.
- `ioctl_dout`  in  8  download data byte.
- `ioctl_wr`  in  1  single-cycle strobe: byte valid.
- `ioctl_wait`  out  1  back-pressure to `hps_io`.
- `mem_addr`  out  ADDRWIDTH  memory write address.
- `mem_data`  out  8  memory write data.
- `mem_wren`  out  1  memory write enable, one cycle per byte.
- `busy`  out  1  high in LOAD, WRITE, FILL.
- `done`  out  1  image complete; held until the next matching download.
- `size`  out  ADDRWIDTH+1  highest written address + 1, saturating at 2^ADDRWIDTH.

## Operation
- Match: `sel = ioctl_download && ioctl_index == INDEX`.
- States are IDLE, LOAD, WRITE, FILL and DONE.
- IDLE/DONE:
  - On `sel` go to LOAD.
  - Clear `size` to 0 and `done` to 0.
- LOAD:
  - On `ioctl_wr` with `ioctl_addr < 2^ADDRWIDTH`, register `mem_addr <= ioctl_addr[ADDRWIDTH-1:0]`, `mem_data <= ioctl_dout` and `mem_wren <= 1`.
  - Update `size <= max(size, ioctl_addr+1)`, then go to WRITE.
  - On `ioctl_wr` with `ioctl_addr >= 2^ADDRWIDTH`, drop the byte with no write. Set `size` to 2^ADDRWIDTH and stay in LOAD.
  - When `sel` falls with no strobe pending: if `size < 2^ADDRWIDTH`, go to FILL with `mem_addr <= size`; else go to DONE.
- WRITE:
  - Hold `ioctl_wait=1` for one cycle while the memory write completes, then return to LOAD.
  - If `sel` has fallen, apply the same exit rule as LOAD.
- FILL:
  - Each cycle write `FILL` at `mem_addr`, with `mem_wren=1`, and increment.
  - The last write is at 2^ADDRWIDTH−1, then go to DONE.
  - Address arithmetic is ADDRWIDTH+1 bits, so there is no wrap to 0.
- DONE: `done=1`, `busy=0`, `mem_wren=0`.
- Writes in LOAD keep arrival order; overlapping addresses are last-writer-wins.
- Downloads with a non-matching index never change any output.
- `ioctl_wr` while `ioctl_wait=1` is a protocol violation by the host; the byte is dropped.
- `sel` rising during FILL aborts the fill, clears `size` and goes to LOAD.

## Timing
- Reset values: state IDLE, `mem_addr=0`, `mem_data=0`, `mem_wren=0`, `ioctl_wait=0`, `busy=0`, `done=0`, `size=0`.
- Reset asserted mid-load or mid-fill returns to IDLE immediately. The memory is not rewritten, and `done` stays 0 until a full load completes.
- Latency:
  - `ioctl_wr` sampled at cycle N gives `mem_wren=1` during cycle N+1 and `ioctl_wait=1` during N+1.
  - Minimum strobe spacing is 2 cycles.
- Fill: exactly 2^ADDRWIDTH − `size` cycles with `mem_wren=1` back-to-back. `done` rises the cycle after the final fill write.
- Zero-byte download (`sel` pulse, no strobes) fills the entire region: 2^ADDRWIDTH writes.
- Exact-size image: no FILL cycles; `done` is high 1 cycle after `sel` falls (after WRITE if pending).
- `busy` goes high the cycle after `sel` rises.
- All outputs are registered; there are no combinational paths from `ioctl_*` to outputs.

## Test plan
- ADDRWIDTH=4, load 16 bytes 0x00..0x0F at addr 0..15 -> 16 single-cycle `mem_wren` with matching addr/data. No FILL writes; `size=16`, `done=1` one cycle after `sel` falls.
- ADDRWIDTH=4, load 5 bytes -> 5 data writes, then 11 consecutive writes of 0xFF at addr 5..15. `done` rises the cycle after the addr-15 write.
- Download with `ioctl_index=INDEX+1` -> no `mem_wren`, `busy=0`, `done` unchanged.
- 20-byte image into depth 16 -> bytes 16..19 dropped; `size=16`; no FILL; no write to addr 0..3 after the first pass.
- Second matching download asserted midway through FILL -> fill stops the next cycle, `size=0`, new data written from its addresses, `done=0` until it completes.
- `reset_n` pulled low during LOAD after 3 bytes -> all outputs at reset values asynchronously. A following full download completes normally with `done=1`.
